fv_bank_req_arbiter: RTL and testbench
======================================

# fv_bank_req_arbiter

Arbitrates Edge-PE read requests and accumulator/vertex-buffer write-back bursts onto the single `Req2Output_SRAM_Bank` request port of one Big FV bank controller. It sits directly upstream of the bank controller. The bank controller has no ready/back-pressure signal, so this block enforces its occupancy itself:
- a read keeps the bank busy for ceil(FV_num/2) lines;
- a write burst keeps it busy until its `wr_eos` beat.

During a transaction the block holds `Node_id` stable, because the controller re-uses it on every line.

## Interface
Parameters:
- `NUM_PE`, 4: number of Edge-PE read requesters; index = `PE_tag`.
- `NUM_WB`, 2: number of write-back sources (0 = accumulator buffer, 1 = vertex buffer).
- `NODE_ID_W`, `$clog2(`Max_Node_id)`: node id width.
- `DATA_W`, `` `FV_bandwidth ``: data beat width.
- `FV_NUM_W`, `$clog2(`Max_FV_num)+1`: feature-count width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `upd_phase` in 1: `Cur_Update_Iter[0]`; new grants are issued only while this is 1.
- `fv_num` in `FV_NUM_W`: features per node; sampled at read grant.
- `rd_valid` in `NUM_PE`: read request valid, one bit per PE.
- `rd_node_id` in `NUM_PE*NODE_ID_W`: per-PE read node id.
- `rd_ready` out `NUM_PE`: read grant; one-hot or zero.
- `wb_valid` in `NUM_WB`: write beat valid.
- `wb_node_id` in `NUM_WB*NODE_ID_W`: burst node id; sampled on the first beat only.
- `wb_data` in `NUM_WB*DATA_W`: write beat data.
- `wb_eos` in `NUM_WB`: marks the last beat of a burst.
- `wb_ready` out `NUM_WB`: write beat accept.
- `req_pkt` out `Req2Output_SRAM_Bank`: {valid, rd_wr, wr_eos, Node_id, PE_tag, data}; registered.
- `busy` out 1: high whenever the block is not in IDLE.
- `proto_err` out 1: sticky flag; set when a write source gaps mid-burst.

## Operation
States:
- IDLE: no transaction in flight; grants can be issued.
- RD_HOLD: a read has been issued and the bank is still streaming it.
- WR_BURST: a write burst is in progress.

Arbitration:
- Requesters are ordered as slots 0..NUM_PE-1 for reads, then NUM_PE..NUM_PE+NUM_WB-1 for writes.
- Selection is round-robin. The pointer resets to 0 and, after each grant, moves to the granted slot + 1 (mod total).
- A grant is issued only when the state is IDLE (or at the RD_HOLD exit point, see Timing), `upd_phase`=1 and at least one valid is pending.
- The grant is the combinational `rd_ready`/`wb_ready` bit of the selected slot.

Read grant:
- Latch node id and PE tag. Latch L = max(1, ceil(fv_num/2)).
- Next cycle: `req_pkt`.valid=1, rd_wr=0.
- Then go to RD_HOLD for L cycles with valid=0 and Node_id/PE_tag held.

Write grant:
- Latch the owner and node id. The first beat is accepted and the state goes to WR_BURST.
- In WR_BURST, `wb_ready[owner]`=1 and all other ready bits are 0.
- Each accepted beat appears on `req_pkt` the next cycle with rd_wr=1, data, wr_eos and the latched Node_id.
- A beat carrying eos (including a single-beat burst taken from IDLE) returns the state to IDLE.

Write gap:
- If the owner drops `wb_valid` while in WR_BURST, that cycle's `req_pkt`.valid=0 and `proto_err` is set.
- The block stays in WR_BURST until eos.

Phase change:
- `upd_phase` falling mid-transaction does not abort it; the transaction completes, after which no new grants are issued.

Reset:
- Resets mid-operation too. State returns to IDLE and the pointer to 0.
- All `req_pkt` fields, `rd_ready`, `wb_ready`, `busy` and `proto_err` are 0.

## Timing
- Read granted at cycle t:
  - packet at t+1;
  - RD_HOLD during t+2..t+1+L;
  - earliest next grant at t+1+L, so the next packet is at t+2+L.
  - This gap is exact (no idle cycle is wasted) and matches the bank controller re-entering IDLE.
- Write:
  - first beat granted at t, packet at t+1;
  - eos beat accepted at e, packet at e+1;
  - earliest next grant at e+1, packet at e+2.
- Grants and packets never overlap an in-flight transaction.
- At most one `rd_ready` or `wb_ready` bit is high in any cycle.
- `fv_num`=0 is treated as L=1. The `fv_num` value used is the one latched at grant, even if the input changes later.

## Structure
- Shared package (`sys_defs`) holds:
  - `Req2Output_SRAM_Bank`;
  - `` `Num_Edge_PE ``, `` `Max_FV_num ``, `` `Max_Node_id ``, `` `FV_bandwidth ``;
  - the new `` `Num_FV_WB_src `` constant.
- Sub-module `rr_pick` (parameterized N): takes request vector and pointer, returns a one-hot grant and the encoded index. It is reused by later bank arbiters.

## Test plan
- **Single read:** `upd_phase`=1, `fv_num`=16, PE2 requests node 0x24 → packet at t+1 with rd_wr=0, PE_tag=2; valid low for 8 cycles with Node_id held; next packet no earlier than t+10.
- **Contention:** all 4 PEs plus WB0 valid → grant order 0,1,2,3,4, then wrap to 0; no overlap between transactions.
- **Write burst:** WB1 sends 4 beats (eos on the 4th) to node 0x10 → 4 consecutive packets with rd_wr=1 and Node_id=0x10, wr_eos on the 4th only; next grant on the cycle after the eos packet.
- **Single-beat write:** eos on the first beat → one packet; IDLE the next cycle.
- **Gap:** WB0 drops valid on beat 2 of a burst → `proto_err`=1 and stays 1; one bubble packet (valid=0); burst completes on eos.
- **Phase and reset:** `upd_phase`=0 with requests pending → no ready bits, `busy`=0. `reset` asserted during RD_HOLD → all outputs 0 the next cycle and the pointer restarts at 0.

Source files
------------

// File: rtl/fv_bank_req_arbiter_pkg.sv
// Shared types and sizing for the Big FV bank request path.
package fv_bank_req_arbiter_pkg;

  localparam int NUM_EDGE_PE   = 4;
  localparam int NUM_FV_WB_SRC = 2;
  localparam int MAX_FV_NUM    = 64;
  localparam int MAX_NODE_ID   = 256;
  localparam int FV_BANDWIDTH  = 32;

  localparam int NODE_ID_BITS = $clog2(MAX_NODE_ID);
  localparam int FV_NUM_BITS  = $clog2(MAX_FV_NUM) + 1;
  localparam int PE_TAG_BITS  = $clog2(NUM_EDGE_PE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_HOLD  = 2'd1,
    ST_WR_BURST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    rd_wr;
    logic                    wr_eos;
    logic [NODE_ID_BITS-1:0] Node_id;
    logic [PE_TAG_BITS-1:0]  PE_tag;
    logic [FV_BANDWIDTH-1:0] data;
  } Req2Output_SRAM_Bank;

  // Lines a read occupies the bank: two features per line, never less than one.
  function automatic logic [FV_NUM_BITS-1:0] rd_lines(input logic [FV_NUM_BITS-1:0] fv_num);
    return (fv_num == '0) ? FV_NUM_BITS'(1) : FV_NUM_BITS'(({1'b0, fv_num} + 1'b1) >> 1);
  endfunction

endpackage

// File: rtl/fv_bank_req_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot grant plus index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] rot;
  logic [IW:0]  sum;

  always_comb begin
    rot = N'({req, req} >> ptr);
    gnt = '0;
    any = 1'b0;
    sum = '0;
    // Descending scan so the lowest rotated position is the one kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW + 1)'(i);
      end
    end
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// Arbitrates Edge-PE reads and write-back bursts onto one bank request port,
// pacing the bank itself since the controller has no back-pressure.
module fv_bank_req_arbiter
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter int NUM_PE    = NUM_EDGE_PE,
  parameter int NUM_WB    = NUM_FV_WB_SRC,
  parameter int NODE_ID_W = NODE_ID_BITS,
  parameter int DATA_W    = FV_BANDWIDTH,
  parameter int FV_NUM_W  = FV_NUM_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          upd_phase,
  input  logic [FV_NUM_W-1:0]           fv_num,
  input  logic [NUM_PE-1:0]             rd_valid,
  input  logic [NUM_PE*NODE_ID_W-1:0]   rd_node_id,
  output logic [NUM_PE-1:0]             rd_ready,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*NODE_ID_W-1:0]   wb_node_id,
  input  logic [NUM_WB*DATA_W-1:0]      wb_data,
  input  logic [NUM_WB-1:0]             wb_eos,
  output logic [NUM_WB-1:0]             wb_ready,
  output Req2Output_SRAM_Bank           req_pkt,
  output logic                          busy,
  output logic                          proto_err
);

  localparam int TOTAL = NUM_PE + NUM_WB;
  localparam int PW    = $clog2(TOTAL);
  localparam int PEW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int WBW   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  arb_state_e          state_q, state_d;
  logic [FV_NUM_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [WBW-1:0]      owner_q, owner_d;
  logic                err_q, err_d;
  Req2Output_SRAM_Bank pkt_q, pkt_d;

  logic [NODE_ID_W-1:0] rd_id  [NUM_PE];
  logic [NODE_ID_W-1:0] wb_id  [NUM_WB];
  logic [DATA_W-1:0]    wb_dat [NUM_WB];

  logic [TOTAL-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any, pick_is_rd, grant_ok, grant;
  logic [PEW-1:0]   rd_sel;
  logic [WBW-1:0]   wb_sel;

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) rd_id[i] = rd_node_id[i*NODE_ID_W +: NODE_ID_W];
    for (int i = 0; i < NUM_WB; i++) begin
      wb_id[i]  = wb_node_id[i*NODE_ID_W +: NODE_ID_W];
      wb_dat[i] = wb_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(.N(TOTAL), .IW(PW)) u_pick (
    .req ({wb_valid, rd_valid}),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_is_rd = pick_idx < PW'(NUM_PE);
  assign rd_sel     = PEW'(pick_idx);
  assign wb_sel     = WBW'(pick_idx - PW'(NUM_PE));

  // The last RD_HOLD line is also a grant slot so back-to-back reads waste no cycle.
  assign grant_ok = !reset && upd_phase &&
                    (state_q == ST_IDLE || (state_q == ST_RD_HOLD && cnt_q == '0));
  assign grant    = grant_ok && pick_any;

  always_comb begin
    rd_ready = '0;
    wb_ready = '0;
    if (!reset && state_q == ST_WR_BURST) begin
      wb_ready[owner_q] = 1'b1;
    end else if (grant) begin
      rd_ready = pick_gnt[NUM_PE-1:0];
      wb_ready = pick_gnt[TOTAL-1:NUM_PE];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    err_d       = err_q;
    pkt_d       = pkt_q;
    pkt_d.valid = 1'b0;

    case (state_q)
      ST_RD_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_IDLE;
      end
      ST_WR_BURST: begin
        if (wb_valid[owner_q]) begin
          pkt_d.valid  = 1'b1;
          pkt_d.rd_wr  = 1'b1;
          pkt_d.wr_eos = wb_eos[owner_q];
          pkt_d.data   = wb_dat[owner_q];
          if (wb_eos[owner_q]) state_d = ST_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (grant) begin
      ptr_d       = (pick_idx == PW'(TOTAL - 1)) ? '0 : pick_idx + 1'b1;
      pkt_d.valid = 1'b1;
      if (pick_is_rd) begin
        pkt_d.rd_wr   = 1'b0;
        pkt_d.wr_eos  = 1'b0;
        pkt_d.Node_id = rd_id[rd_sel];
        pkt_d.PE_tag  = PE_TAG_BITS'(rd_sel);
        cnt_d         = rd_lines(fv_num);
        state_d       = ST_RD_HOLD;
      end else begin
        pkt_d.rd_wr   = 1'b1;
        pkt_d.wr_eos  = wb_eos[wb_sel];
        pkt_d.Node_id = wb_id[wb_sel];
        pkt_d.PE_tag  = '0;
        pkt_d.data    = wb_dat[wb_sel];
        owner_d       = wb_sel;
        state_d       = wb_eos[wb_sel] ? ST_IDLE : ST_WR_BURST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      pkt_q   <= pkt_d;
    end
  end

  assign req_pkt   = pkt_q;
  assign busy      = (state_q != ST_IDLE);
  assign proto_err = err_q;

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a cycle-level occupancy model.
module tb_fv_bank_req_arbiter;
  import fv_bank_req_arbiter_pkg::*;

  localparam int NPE = 4, NWB = 2, NS = 6, IDW = 8, DW = 32, FW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, upd_phase;
  logic [FW-1:0]       fv_num;
  logic [NPE-1:0]      rd_valid, rd_ready;
  logic [NPE*IDW-1:0]  rd_node_id;
  logic [NWB-1:0]      wb_valid, wb_eos, wb_ready;
  logic [NWB*IDW-1:0]  wb_node_id;
  logic [NWB*DW-1:0]   wb_data;
  Req2Output_SRAM_Bank req_pkt;
  logic                busy, proto_err;

  fv_bank_req_arbiter dut (
    .clk(clk), .reset(reset), .upd_phase(upd_phase), .fv_num(fv_num),
    .rd_valid(rd_valid), .rd_node_id(rd_node_id), .rd_ready(rd_ready),
    .wb_valid(wb_valid), .wb_node_id(wb_node_id), .wb_data(wb_data),
    .wb_eos(wb_eos), .wb_ready(wb_ready), .req_pkt(req_pkt),
    .busy(busy), .proto_err(proto_err)
  );

  int n_vec = 0, n_err = 0;

  // Model: the bank is free for a new grant from m_grant_from; busy through m_busy_until or while a burst is open.
  int                  cyc, m_ptr, m_busy_until, m_grant_from, m_owner;
  bit                  m_in_wr, m_err;
  logic [IDW-1:0]      m_wr_node;
  Req2Output_SRAM_Bank m_pkt;
  int                  order[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    cyc = 0; m_ptr = 0; m_busy_until = -1; m_grant_from = 0; m_owner = 0;
    m_in_wr = 0; m_err = 0; m_wr_node = '0; m_pkt = '0;
  endtask

  task automatic step();
    logic [NPE-1:0]      e_rd;
    logic [NWB-1:0]      e_wb;
    logic [NS-1:0]       reqv;
    Req2Output_SRAM_Bank cur, nx;
    bit                  e_busy, cur_err;
    int                  s, w, slot, fv, len;
    #1;
    cur = m_pkt; cur_err = m_err;
    e_busy = m_in_wr || (cyc <= m_busy_until);
    e_rd = '0; e_wb = '0;
    nx = m_pkt; nx.valid = 1'b0;
    reqv = {wb_valid, rd_valid};
    if (reset) begin
      nx = '0; m_ptr = 0; m_in_wr = 0; m_busy_until = -1; m_grant_from = 0; m_err = 0;
    end else if (m_in_wr) begin
      e_wb[m_owner] = 1'b1;
      if (wb_valid[m_owner]) begin
        nx.valid = 1; nx.rd_wr = 1; nx.wr_eos = wb_eos[m_owner];
        nx.Node_id = m_wr_node; nx.data = wb_data[m_owner*DW +: DW];
        if (wb_eos[m_owner]) begin m_in_wr = 0; m_grant_from = cyc + 1; end
      end else begin
        m_err = 1;
      end
    end else if (upd_phase && cyc >= m_grant_from) begin
      s = -1;
      for (int k = 0; k < NS; k++) begin
        slot = (m_ptr + k) % NS;
        if (s < 0 && reqv[slot]) s = slot;
      end
      if (s >= 0) begin
        m_ptr = (s + 1) % NS;
        nx.valid = 1;
        if (s < NPE) begin
          e_rd[s] = 1'b1;
          fv = int'(fv_num);
          len = (fv == 0) ? 1 : (fv + 1) / 2;
          nx.rd_wr = 0; nx.wr_eos = 0;
          nx.Node_id = rd_node_id[s*IDW +: IDW];
          nx.PE_tag = PE_TAG_BITS'(s);
          m_busy_until = cyc + 1 + len;
          m_grant_from = cyc + 1 + len;
        end else begin
          w = s - NPE;
          e_wb[w] = 1'b1;
          nx.rd_wr = 1; nx.wr_eos = wb_eos[w];
          nx.Node_id = wb_node_id[w*IDW +: IDW];
          nx.data = wb_data[w*DW +: DW];
          m_wr_node = wb_node_id[w*IDW +: IDW];
          if (wb_eos[w]) m_grant_from = cyc + 1;
          else begin m_in_wr = 1; m_owner = w; end
        end
      end
    end
    chk("rd_ready", rd_ready, e_rd);
    chk("wb_ready", wb_ready, e_wb);
    chk("busy", busy, e_busy);
    chk("proto_err", proto_err, cur_err);
    chk("pkt_valid", req_pkt.valid, cur.valid);
    if (cur.valid) begin
      chk("pkt_rd_wr", req_pkt.rd_wr, cur.rd_wr);
      chk("pkt_eos", req_pkt.wr_eos, cur.wr_eos);
      chk("pkt_node", req_pkt.Node_id, cur.Node_id);
      if (cur.rd_wr) chk("pkt_data", req_pkt.data, cur.data);
      else           chk("pkt_tag", req_pkt.PE_tag, cur.PE_tag);
    end else if (e_busy) begin
      chk("held_node", req_pkt.Node_id, cur.Node_id);
    end
    m_pkt = nx;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    rd_valid = '0; wb_valid = '0; wb_eos = '0;
    for (int i = 0; i < 80; i++) begin
      if (!m_in_wr && cyc > m_busy_until) break;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t, next_pkt;
    int exp_order[6];
    logic [1:0] gap_v [4];
    exp_order = '{0, 1, 2, 3, 4, 0};
    gap_v = '{2'b01, 2'b00, 2'b01, 2'b01};

    reset = 1; upd_phase = 0; fv_num = '0; rd_valid = '0; rd_node_id = '0;
    wb_valid = '0; wb_eos = '0; wb_node_id = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_pkt", req_pkt, '0);
    chk("rst_busy", busy, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_ready", {wb_ready, rd_ready}, '0);
    model_init();
    reset = 0;

    // Contention from a fresh pointer
    upd_phase = 1; fv_num = 7'd2; rd_valid = 4'hf;
    rd_node_id = {8'h33, 8'h22, 8'h11, 8'h05};
    wb_valid = 2'b01; wb_eos = 2'b01; wb_node_id = {8'h00, 8'h40}; wb_data = {32'h0, 32'hA0A0_0001};
    for (int i = 0; i < 80 && order.size() < 6; i++) begin
      #1;
      for (int k = 0; k < NPE; k++) if (rd_ready[k]) order.push_back(k);
      for (int k = 0; k < NWB; k++) if (wb_ready[k]) order.push_back(NPE + k);
      step();
    end
    chk("rr_count", order.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    drain();

    // Single read, fv_num changed after grant
    fv_num = 7'd16; rd_valid = 4'b0100; rd_node_id = {8'h33, 8'h24, 8'h11, 8'h05};
    t = cyc;
    step();
    fv_num = 7'd2;
    chk("rd1_valid", req_pkt.valid, 1);
    chk("rd1_rdwr", req_pkt.rd_wr, 0);
    chk("rd1_tag", req_pkt.PE_tag, 2);
    chk("rd1_node", req_pkt.Node_id, 8'h24);
    next_pkt = -1;
    for (int i = 0; i < 30 && next_pkt < 0; i++) begin
      step();
      if (req_pkt.valid) next_pkt = cyc;
    end
    chk("rd_next_gap", next_pkt - t, 10);
    drain();

    // Four-beat write burst from WB1; node id sampled on the first beat only
    wb_valid = 2'b10; wb_node_id = {8'h10, 8'h00};
    for (int k = 0; k < 4; k++) begin
      wb_eos = (k == 3) ? 2'b10 : 2'b00;
      wb_data = {32'hB000_0000 + 32'(k), 32'h0};
      step();
      wb_node_id = {8'hEE, 8'h00};
      chk("wr_valid", req_pkt.valid, 1);
      chk("wr_rdwr", req_pkt.rd_wr, 1);
      chk("wr_node", req_pkt.Node_id, 8'h10);
      chk("wr_eos", req_pkt.wr_eos, (k == 3));
      chk("wr_data", req_pkt.data, 32'hB000_0000 + 32'(k));
    end
    chk("wr_idle_after_eos", busy, 0);
    wb_valid = '0; wb_eos = '0; rd_valid = 4'b0001; fv_num = 7'd0;
    #1;
    chk("grant_after_eos", rd_ready, 4'b0001);
    step();
    drain();

    // Single-beat write
    wb_valid = 2'b01; wb_eos = 2'b01; wb_node_id = {8'h00, 8'h55}; wb_data = {32'h0, 32'h0000_C0DE};
    step();
    wb_valid = '0; wb_eos = '0;
    chk("sb_valid", req_pkt.valid, 1);
    chk("sb_eos", req_pkt.wr_eos, 1);
    chk("sb_node", req_pkt.Node_id, 8'h55);
    chk("sb_idle", busy, 0);
    step();
    chk("sb_one_pkt", req_pkt.valid, 0);

    // Mid-burst gap on WB0
    wb_node_id = {8'h00, 8'h66};
    for (int k = 0; k < 4; k++) begin
      wb_valid = gap_v[k];
      wb_eos = (k == 3) ? 2'b01 : 2'b00;
      wb_data = {32'h0, 32'hD000_0000 + 32'(k)};
      step();
      if (k == 1) begin
        chk("gap_bubble", req_pkt.valid, 0);
        chk("gap_err", proto_err, 1);
      end
    end
    chk("gap_eos_pkt", req_pkt.wr_eos, 1);
    chk("gap_done_idle", busy, 0);
    drain();
    step();
    chk("gap_err_sticky", proto_err, 1);

    // Phase low with everything pending
    upd_phase = 0; rd_valid = 4'hf; wb_valid = 2'b11; wb_eos = '0;
    repeat (4) begin
      #1;
      chk("phase_rd", rd_ready, 0);
      chk("phase_wb", wb_ready, 0);
      step();
      chk("phase_busy", busy, 0);
    end

    // Reset in RD_HOLD after a grant that moved the pointer
    upd_phase = 1; rd_valid = 4'b0010; wb_valid = '0; fv_num = 7'd20;
    repeat (3) step();
    chk("hold_busy", busy, 1);
    reset = 1; rd_valid = '0;
    step();
    rd_valid = 4'hf;
    #1;
    chk("mid_rst_pkt", req_pkt, '0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", proto_err, 0);
    chk("mid_rst_ready", {wb_ready, rd_ready}, '0);
    step();
    reset = 0;
    #1;
    chk("ptr_restart", rd_ready, 4'b0001);
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom % 400 == 0);
      upd_phase  = ($urandom % 8 != 0);
      fv_num     = ($urandom % 16 == 0) ? 7'd64 : 7'($urandom_range(0, 12));
      rd_valid   = 4'($urandom);
      rd_node_id = 32'($urandom);
      wb_valid   = {($urandom % 4 != 0), ($urandom % 4 != 0)};
      wb_eos     = {($urandom % 3 == 0), ($urandom % 3 == 0)};
      wb_node_id = 16'($urandom);
      wb_data    = {32'($urandom), 32'($urandom)};
      step();
    end
    reset = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
